enigma_seq: RTL and testbench
=============================

ENIGMA_SEQ -- requirements
Module: enigma_seq

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 64, giving the core-response watchdog limit in clock cycles (range 2..65535).
REQ-002 The block SHALL have the following ports, one per line, as name, direction, width, meaning:
  clk  input  1  single clock, rising edge.
  reset_n  input  1  asynchronous, active-low reset.
  start  input  1  single-cycle pulse that begins a message.
  dec_in  input  1  mode sampled at start: 1 = decrypt, 0 = encrypt.
  len  input  16  character count of the message, sampled at start.
  s_valid / s_data / s_ready  in / in / out  1/8/1  input byte stream.
  m_valid / m_data / m_ready  out / out / in  1/8/1  output byte stream.
  core_set  output  1  one-cycle rotor/reflector load strobe.
  core_en  output  1  rotor stepping enable.
  core_valid / core_din  output  1/8  character issue to the cipher core.
  core_dec  output  1  latched mode to the core.
  core_dout / core_done  input  8/1  core result and completion pulse.
  busy  output  1  high whenever the state is not IDLE.
  msg_done  output  1  one-cycle pulse at message completion.
  err  output  1  sticky watchdog error flag.

Function
REQ-003 The FSM SHALL have the states IDLE, SET, ACCEPT, ISSUE, WAIT and EMIT, with exactly one character in flight at a time.
REQ-004 In IDLE, start with len != 0 SHALL latch len into the remaining counter and dec_in into core_dec, clear err, and go to SET.
REQ-005 In IDLE, start with len == 0 SHALL pulse msg_done on the next cycle and remain in IDLE.
REQ-006 start outside IDLE SHALL be ignored.
REQ-007 In SET, core_set SHALL be 1 for exactly one cycle, then the FSM goes to ACCEPT.
REQ-008 core_en SHALL be 1 in ACCEPT, ISSUE, WAIT and EMIT, and 0 otherwise.
REQ-009 In ACCEPT, s_ready SHALL be 1; s_ready SHALL be 0 in every other state.
REQ-010 On an s_valid && s_ready handshake, the block SHALL latch s_data; a byte in 8'h41..8'h5A goes to ISSUE, and any other byte goes to EMIT unchanged (bypass: not sent to the core, rotors not stepped).
REQ-011 In ISSUE, core_valid SHALL be 1 for exactly one cycle with core_din equal to the latched byte; the watchdog counter is cleared and the FSM goes to WAIT.
REQ-012 In WAIT, core_done SHALL latch core_dout into m_data and move the FSM to EMIT.
REQ-013 core_done in any state other than WAIT SHALL be ignored.
REQ-014 In EMIT, m_valid SHALL be 1 and m_data SHALL be held stable until m_ready is 1.
REQ-015 On the m_valid && m_ready handshake, remaining SHALL decrement by 1; if remaining reaches 0, msg_done pulses on the next cycle and the FSM goes to IDLE, otherwise it goes to ACCEPT.
REQ-016 Latency SHALL be: s handshake at cycle t gives core_valid at t+1; core_done at cycle u gives m_valid at u+1; a bypass byte gives m_valid at t+1.
REQ-017 The remaining counter SHALL be 16 bits and SHALL never wrap; a length of 65535 is legal.

Reset
REQ-018 reset_n low SHALL force state IDLE and clear all counters and registered data to 0.
REQ-019 During reset, every output SHALL be 0, including core_dec, err and m_data.
REQ-020 Reset mid-message SHALL abandon the message with no msg_done pulse; the rotors are reloaded by core_set on the next start.

Configuration
REQ-021 With ENIGMA_SEQ_TIMEOUT_EN defined, a 16-bit counter SHALL count cycles in WAIT; when it reaches TIMEOUT without core_done, err sets (sticky until the next accepted start), m_data is loaded with 8'h3F, and the FSM goes to EMIT.
REQ-022 A core_done arriving after a timeout SHALL be ignored.
REQ-023 Without ENIGMA_SEQ_TIMEOUT_EN, WAIT SHALL wait for core_done indefinitely, err SHALL be tied to 0, and no watchdog counter is present.

Verification
REQ-024 Bench case: start, len=3, dec_in=0, input "ABC", core model returns din+1 after 5 cycles -> output "BCD", one core_set pulse, msg_done one cycle after the third m handshake.
REQ-025 Bench case: input "A B" (8'h20 in the middle), len=3 -> exactly two core_valid pulses, and 8'h20 is output at t+1 after its s handshake.
REQ-026 Bench case: m_ready held at 0 for 10 cycles in EMIT -> m_valid and m_data stay stable, s_ready stays 0, and no further core_valid is issued.
REQ-027 Bench case: start with len=0 -> msg_done pulses once, core_set never asserts, and busy stays 0.
REQ-028 Bench case with ENIGMA_SEQ_TIMEOUT_EN and TIMEOUT=8: core never responds -> after 8 WAIT cycles err=1 and m_data=8'h3F; a late core_done is ignored; the next start clears err.
REQ-029 Bench case: reset_n pulsed low during WAIT of a len=4 message -> all outputs are 0 immediately, there is no msg_done, and a new start then runs normally.

Source files
------------

// File: rtl/enigma_seq_if.sv
// Byte-stream bundle for enigma_seq: input stream (s_*) and output stream (m_*).
// The slave modport is the sequencer's view; the master modport is the producer/consumer side.
interface enigma_seq_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready;

   modport master (
      output s_valid, s_data,
      input  s_ready,
      input  m_valid, m_data,
      output m_ready
   );

   modport slave (
      input  s_valid, s_data,
      output s_ready,
      output m_valid, m_data,
      input  m_ready
   );
endinterface

// File: rtl/enigma_seq.sv
// Message sequencer for an Enigma cipher core: one character in flight, letters go to the core, others bypass.
// Optional core-response watchdog enabled by defining ENIGMA_SEQ_TIMEOUT_EN.
module enigma_seq #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        dec_in,
   input  logic [15:0] len,
   enigma_seq_if.slave strm,
   output logic        core_set,
   output logic        core_en,
   output logic        core_valid,
   output logic [7:0]  core_din,
   output logic        core_dec,
   input  logic [7:0]  core_dout,
   input  logic        core_done,
   output logic        busy,
   output logic        msg_done,
   output logic        err
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SET    = 3'd1,
      ST_ACCEPT = 3'd2,
      ST_ISSUE  = 3'd3,
      ST_WAIT   = 3'd4,
      ST_EMIT   = 3'd5
   } state_t;

   state_t      state_r, state_nx;
   logic [15:0] remaining_r;
   logic [7:0]  byte_r, m_data_r;
   logic        core_dec_r, msg_done_r;
   logic        core_set_r, core_en_r, core_valid_r, s_ready_r, m_valid_r, busy_r;
   logic        set_nx_s, en_nx_s, valid_nx_s, s_ready_nx_s, m_valid_nx_s, busy_nx_s;
   logic        s_hs_s, m_hs_s, accept_s, empty_s, done_s, last_s, timeout_s;

   function automatic logic is_alpha(input logic [7:0] c);
      return (c >= 8'h41) && (c <= 8'h5A);
   endfunction

   assign s_hs_s   = strm.s_valid && s_ready_r;
   assign m_hs_s   = m_valid_r && strm.m_ready;
   assign accept_s = (state_r == ST_IDLE) && start && (len != 16'd0);
   assign empty_s  = (state_r == ST_IDLE) && start && (len == 16'd0);
   assign done_s   = (state_r == ST_WAIT) && core_done;
   assign last_s   = (remaining_r == 16'd1);

`ifdef ENIGMA_SEQ_TIMEOUT_EN
   localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 32'd1);

   logic [15:0] wdog_r;
   logic        err_r;

   // core_done on the final allowed cycle still wins over the timeout
   assign timeout_s = (state_r == ST_WAIT) && !core_done && (wdog_r == WDOG_LAST);
   assign err       = err_r;

   // Watchdog: counts cycles spent waiting for the core
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wdog_r <= 16'd0;
      end else if (state_r == ST_ISSUE) begin
         wdog_r <= 16'd0;
      end else if (state_r == ST_WAIT) begin
         wdog_r <= wdog_r + 16'd1;
      end else begin
         wdog_r <= wdog_r;
      end
   end

   // Sticky error flag, cleared by the next accepted message
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_r <= 1'b0;
      end else if (accept_s) begin
         err_r <= 1'b0;
      end else if (timeout_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end
`else
   // TIMEOUT has no effect without the watchdog
   assign timeout_s = 1'b0 & (TIMEOUT > 32'd0);
   assign err       = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) state_nx = ST_SET;
            else          state_nx = ST_IDLE;
         end
         ST_SET:    state_nx = ST_ACCEPT;
         ST_ACCEPT: begin
            if (s_hs_s) state_nx = is_alpha(strm.s_data) ? ST_ISSUE : ST_EMIT;
            else        state_nx = ST_ACCEPT;
         end
         ST_ISSUE:  state_nx = ST_WAIT;
         ST_WAIT: begin
            if (done_s || timeout_s) state_nx = ST_EMIT;
            else                     state_nx = ST_WAIT;
         end
         ST_EMIT: begin
            if (m_hs_s) state_nx = last_s ? ST_IDLE : ST_ACCEPT;
            else        state_nx = ST_EMIT;
         end
         default:   state_nx = ST_IDLE;
      endcase
   end

   // Output decode of the upcoming state, so the strobes leave straight from flops
   always_comb begin
      set_nx_s     = 1'b0;
      en_nx_s      = 1'b0;
      valid_nx_s   = 1'b0;
      s_ready_nx_s = 1'b0;
      m_valid_nx_s = 1'b0;
      busy_nx_s    = 1'b1;
      case (state_nx)
         ST_IDLE:   busy_nx_s = 1'b0;
         ST_SET:    set_nx_s  = 1'b1;
         ST_ACCEPT: begin
            en_nx_s      = 1'b1;
            s_ready_nx_s = 1'b1;
         end
         ST_ISSUE: begin
            en_nx_s    = 1'b1;
            valid_nx_s = 1'b1;
         end
         ST_WAIT:   en_nx_s = 1'b1;
         ST_EMIT: begin
            en_nx_s      = 1'b1;
            m_valid_nx_s = 1'b1;
         end
         default:   busy_nx_s = 1'b0;
      endcase
   end

   // Registered control outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         core_set_r   <= 1'b0;
         core_en_r    <= 1'b0;
         core_valid_r <= 1'b0;
         s_ready_r    <= 1'b0;
         m_valid_r    <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         core_set_r   <= set_nx_s;
         core_en_r    <= en_nx_s;
         core_valid_r <= valid_nx_s;
         s_ready_r    <= s_ready_nx_s;
         m_valid_r    <= m_valid_nx_s;
         busy_r       <= busy_nx_s;
      end
   end

   // Message datapath: length, mode, character and result registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         remaining_r <= 16'd0;
         core_dec_r  <= 1'b0;
         byte_r      <= 8'd0;
         m_data_r    <= 8'd0;
         msg_done_r  <= 1'b0;
      end else begin
         msg_done_r <= empty_s || (m_hs_s && last_s);
         if (accept_s) begin
            remaining_r <= len;
            core_dec_r  <= dec_in;
         end else if (m_hs_s && (remaining_r != 16'd0)) begin
            remaining_r <= remaining_r - 16'd1;
         end else begin
            remaining_r <= remaining_r;
         end
         if (s_hs_s) byte_r <= strm.s_data;
         else        byte_r <= byte_r;
         // bypassed bytes skip the core and go straight to the output register
         if (s_hs_s && !is_alpha(strm.s_data)) m_data_r <= strm.s_data;
         else if (done_s)                      m_data_r <= core_dout;
         else if (timeout_s)                   m_data_r <= 8'h3F;
         else                                  m_data_r <= m_data_r;
      end
   end

   assign core_set     = core_set_r;
   assign core_en      = core_en_r;
   assign core_valid   = core_valid_r;
   assign core_din     = byte_r;
   assign core_dec     = core_dec_r;
   assign busy         = busy_r;
   assign msg_done     = msg_done_r;
   assign strm.s_ready = s_ready_r;
   assign strm.m_valid = m_valid_r;
   assign strm.m_data  = m_data_r;

endmodule

// File: tb/tb_enigma_seq.sv
// Self-checking bench for enigma_seq: random messages against an end-to-end character model.
// Define ENIGMA_SEQ_TIMEOUT_EN to also exercise the watchdog with TIMEOUT=8.
module tb_enigma_seq;
`ifdef ENIGMA_SEQ_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 64;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        dec_in = 1'b0;
   logic [15:0] len = 16'd0;
   logic        core_set, core_en, core_valid, core_dec, busy, msg_done, err;
   logic [7:0]  core_din;
   logic [7:0]  core_dout;
   logic        core_done;

   int          n_checks = 0;
   int          n_errors = 0;
   int          core_lat = 3;
   logic [7:0]  in_q[$];

   logic        cm_busy;
   int          cm_cnt;
   logic [7:0]  cm_res;

   enigma_seq_if sif ();

   enigma_seq #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .dec_in     (dec_in),
      .len        (len),
      .strm       (sif),
      .core_set   (core_set),
      .core_en    (core_en),
      .core_valid (core_valid),
      .core_din   (core_din),
      .core_dec   (core_dec),
      .core_dout  (core_dout),
      .core_done  (core_done),
      .busy       (busy),
      .msg_done   (msg_done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Cipher core stand-in: answers din+1 (encrypt) or din-1 (decrypt) after core_lat cycles
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cm_busy   <= 1'b0;
         cm_cnt    <= 0;
         cm_res    <= 8'd0;
         core_done <= 1'b0;
         core_dout <= 8'd0;
      end else begin
         core_done <= 1'b0;
         if (cm_busy) begin
            if (cm_cnt <= 1) begin
               core_done <= 1'b1;
               core_dout <= cm_res;
               cm_busy   <= 1'b0;
            end else begin
               cm_cnt <= cm_cnt - 1;
            end
         end else if (core_valid) begin
            cm_busy <= 1'b1;
            cm_cnt  <= core_lat;
            cm_res  <= core_dec ? core_din - 8'd1 : core_din + 8'd1;
         end
      end
   end

   function automatic logic is_alpha(input logic [7:0] c);
      return (c >= 8'h41) && (c <= 8'h5A);
   endfunction

   // End-to-end expectation for one character
   function automatic logic [7:0] ref_char(input logic [7:0] c, input logic dec);
      if (!is_alpha(c)) return c;
      return dec ? c - 8'd1 : c + 8'd1;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_msg(input int n, input logic dec_v, input int stall_at);
      logic [7:0] exp_q[$];
      int   sent, recv, cv_cnt, set_cnt, alpha_cnt, stall_left, budget;
      logic s_pend, cd_pend, done_exp, finished, prev_mv, prev_mr;
      logic [7:0] s_byte, cd_byte, prev_md;
      sent = 0; recv = 0; cv_cnt = 0; set_cnt = 0; alpha_cnt = 0; stall_left = 10;
      s_pend = 1'b0; cd_pend = 1'b0; done_exp = 1'b0; finished = 1'b0;
      prev_mv = 1'b0; prev_mr = 1'b0; s_byte = 8'd0; cd_byte = 8'd0; prev_md = 8'd0;
      foreach (in_q[i]) begin
         exp_q.push_back(ref_char(in_q[i], dec_v));
         if (is_alpha(in_q[i])) alpha_cnt++;
      end
      budget = 100 + n * 40;
      @(negedge clk);
      start = 1'b1; len = 16'(n); dec_in = dec_v;
      for (int cyc = 0; cyc < budget && !finished; cyc++) begin
         @(negedge clk);
         if (cyc == 0) begin
            start = 1'b0;
            check_eq("busy_on", busy, 1);
            check_eq("set_first", core_set, 1);
            check_eq("dec_latch", core_dec, dec_v);
         end
         if (core_set) set_cnt++;
         if (core_valid) cv_cnt++;
         check_eq("err_clear", err, 0);
         if (s_pend) begin
            if (is_alpha(s_byte)) begin
               check_eq("issue_lat", core_valid, 1);
               check_eq("core_din", core_din, s_byte);
            end else begin
               check_eq("bypass_lat", sif.m_valid, 1);
               check_eq("bypass_data", sif.m_data, s_byte);
            end
         end
         if (cd_pend) begin
            check_eq("done_lat", sif.m_valid, 1);
            check_eq("done_data", sif.m_data, cd_byte);
         end
         cd_pend = core_done;
         cd_byte = core_dout;
         check_eq("msg_done", msg_done, done_exp);
         if (msg_done) finished = 1'b1;
         done_exp = 1'b0;
         if (prev_mv && !prev_mr) begin
            check_eq("m_hold_valid", sif.m_valid, 1);
            check_eq("m_hold_data", sif.m_data, prev_md);
            check_eq("stall_s_ready", sif.s_ready, 0);
            check_eq("stall_core_valid", core_valid, 0);
         end
         if (sif.s_ready || core_valid || sif.m_valid) check_eq("core_en", core_en, 1);
         if (core_set) check_eq("core_en_set", core_en, 0);
         if (sif.m_valid) begin
            if (recv == stall_at && stall_left > 0) begin
               sif.m_ready = 1'b0;
               stall_left--;
            end else begin
               sif.m_ready = ($urandom_range(0, 3) != 0);
            end
            if (sif.m_ready) begin
               check_eq("m_in_range", (recv < n), 1);
               if (recv < n) check_eq("m_data", sif.m_data, exp_q[recv]);
               recv++;
               done_exp = (recv == n);
            end
         end else begin
            sif.m_ready = 1'($urandom_range(0, 1));
         end
         prev_mv = sif.m_valid;
         prev_mr = sif.m_ready;
         prev_md = sif.m_data;
         s_pend = 1'b0;
         if (!finished && sent < n) begin
            sif.s_data  = in_q[sent];
            sif.s_valid = ($urandom_range(0, 3) != 0);
            if (sif.s_valid && sif.s_ready) begin
               s_pend = 1'b1;
               s_byte = in_q[sent];
               sent++;
            end
         end else begin
            sif.s_valid = 1'b0;
         end
         // starts while busy must be ignored
         if (!finished && busy) begin
            start  = ($urandom_range(0, 7) == 0);
            len    = 16'($urandom);
            dec_in = ~dec_v;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0; sif.s_valid = 1'b0; sif.m_ready = 1'b0;
      check_eq("msg_finished", finished, 1);
      check_eq("core_set_count", set_cnt, 1);
      check_eq("core_valid_count", cv_cnt, alpha_cnt);
      check_eq("m_count", recv, n);
      check_eq("s_count", sent, n);
      check_eq("busy_off", busy, 0);
   endtask

   task automatic rand_msg(input int n);
      in_q.delete();
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 2) != 0) in_q.push_back(8'h41 + 8'($urandom_range(0, 25)));
         else                           in_q.push_back(8'($urandom_range(0, 255)));
      end
   endtask

   initial begin
      int pulses, set_seen, busy_seen, hit, sent, t0, t1;
      sif.s_valid = 1'b0; sif.s_data = 8'd0; sif.m_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_ctrl", {core_set, core_en, core_valid, core_dec, busy, msg_done, err,
                            sif.s_ready, sif.m_valid}, 0);
      check_eq("rst_m_data", sif.m_data, 0);
      check_eq("rst_core_din", core_din, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      core_lat = 5;
      in_q = '{8'h41, 8'h42, 8'h43};
      run_msg(3, 1'b0, -1);

      core_lat = 3;
      in_q = '{8'h41, 8'h20, 8'h42};
      run_msg(3, 1'b0, -1);

      in_q = '{8'h51, 8'h2A, 8'h5A, 8'h41};
      run_msg(4, 1'b1, 1);

      // zero-length message
      pulses = 0; set_seen = 0; busy_seen = 0;
      @(negedge clk);
      start = 1'b1; len = 16'd0;
      @(negedge clk);
      start = 1'b0;
      check_eq("len0_done_next", msg_done, 1);
      for (int i = 0; i < 6; i++) begin
         if (msg_done) pulses++;
         if (core_set) set_seen++;
         if (busy) busy_seen++;
         @(negedge clk);
      end
      check_eq("len0_pulses", pulses, 1);
      check_eq("len0_no_set", set_seen, 0);
      check_eq("len0_no_busy", busy_seen, 0);

      for (int k = 0; k < 10; k++) begin
         int n;
         n = $urandom_range(1, 12);
         core_lat = $urandom_range(1, 4);
         rand_msg(n);
         run_msg(n, 1'($urandom_range(0, 1)), (k % 3 == 0) ? int'($urandom_range(0, n - 1)) : -1);
      end

`ifdef ENIGMA_SEQ_TIMEOUT_EN
      // core answers far too late: watchdog fires, late answer ignored
      core_lat = 20; t0 = -1; t1 = -1;
      @(negedge clk);
      start = 1'b1; len = 16'd1; dec_in = 1'b0;
      @(negedge clk);
      start = 1'b0; sif.s_valid = 1'b1; sif.s_data = 8'h4B; sif.m_ready = 1'b0;
      for (int cyc = 0; cyc < 40 && t1 < 0; cyc++) begin
         @(negedge clk);
         if (core_valid) begin
            t0 = cyc;
            sif.s_valid = 1'b0;
         end
         if (sif.m_valid) t1 = cyc;
      end
      check_eq("tmo_seen_issue", (t0 >= 0), 1);
      check_eq("tmo_wait_cycles", t1 - t0, 9);
      check_eq("tmo_err", err, 1);
      check_eq("tmo_m_data", sif.m_data, 8'h3F);
      pulses = 0;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (core_done) pulses++;
         check_eq("tmo_late_data", sif.m_data, 8'h3F);
         check_eq("tmo_hold_valid", sif.m_valid, 1);
      end
      check_eq("tmo_late_done_sent", pulses, 1);
      sif.m_ready = 1'b1;
      @(negedge clk);
      sif.m_ready = 1'b0;
      check_eq("tmo_msg_done", msg_done, 1);
      check_eq("tmo_err_sticky", err, 1);
      core_lat = 2;
      in_q = '{8'h4D, 8'h4E};
      run_msg(2, 1'b0, -1);
`endif

      // reset while the core is working on a character
      core_lat = 4; hit = 0; sent = 0;
      in_q = '{8'h2E, 8'h51, 8'h52, 8'h53};
      @(negedge clk);
      start = 1'b1; len = 16'd4; dec_in = 1'b1;
      @(negedge clk);
      start = 1'b0; sif.m_ready = 1'b1;
      for (int cyc = 0; cyc < 60 && hit == 0; cyc++) begin
         @(negedge clk);
         if (core_valid) hit = 1;
         sif.s_valid = 1'b0;
         if (hit == 0 && sif.s_ready && sent < 4) begin
            sif.s_valid = 1'b1;
            sif.s_data  = in_q[sent];
            sent++;
         end
      end
      check_eq("rstw_reached_issue", hit, 1);
      @(negedge clk);
      sif.s_valid = 1'b0; sif.m_ready = 1'b0;
      reset_n = 1'b0;
      #1;
      check_eq("rstw_ctrl", {core_set, core_en, core_valid, core_dec, busy, msg_done, err,
                             sif.s_ready, sif.m_valid}, 0);
      check_eq("rstw_m_data", sif.m_data, 0);
      check_eq("rstw_core_din", core_din, 0);
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (msg_done) pulses++;
      end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (msg_done) pulses++;
      end
      check_eq("rstw_no_msg_done", pulses, 0);
      in_q = '{8'h48, 8'h21, 8'h49, 8'h4A};
      run_msg(4, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed hang, expected completion");
      $fatal(1, "bench time limit reached");
   end

endmodule
